// File: rtl/tetris_input_pkg.sv
// Shared types and constants for the Tetris board-input path.
// Used by the key channels and by the key repeat controller.
package tetris_input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_fsm_t;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_ROT   = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_DROP  = 3;

  // One counter width serves debounce, DAS and ARR so every compare is exact.
  function automatic int cnt_width(input int deb, input int das, input int arr);
    int m;
    m = deb;
    if (das > m) m = das;
    if (arr > m) m = arr;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One KEY input: 2-FF synchronizer, tick-paced debounce, and the
// DAS/ARR auto-repeat state machine that produces the fire strobe.
module key_channel
  import tetris_input_pkg::*;
#(
  parameter int DEB_TICKS = 2,
  parameter int DAS_TICKS = 20,
  parameter int ARR_TICKS = 5,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic tick_i,
  input  logic key_n_i,
  output logic key_held_o,
  output logic fire_o
);

  localparam int CNT_W = cnt_width(DEB_TICKS, DAS_TICKS, ARR_TICKS);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_TICKS - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             k_s;
  logic             held_q;
  logic [CNT_W-1:0] deb_cnt_q;
  key_fsm_t         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             das_done;
  logic             arr_done;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ~key_n_i};
    end
  end

  assign k_s = sync_q[1];

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      held_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else if (tick_i) begin
      if (k_s != held_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          held_q    <= k_s;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CNT_ONE;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign das_done = (cnt_q == DAS_LAST);
  assign arr_done = (cnt_q == ARR_LAST);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fire_o = 1'b0;
    if (tick_i && held_q) begin
      case (state_q)
        IDLE:    fire_o = 1'b1;
        DELAY:   fire_o = REPEAT_EN && das_done;
        REPEAT:  fire_o = arr_done;
        default: fire_o = 1'b0;
      endcase
    end
  end

  // Without repeat, DELAY parks the counter at DAS_LAST instead of wrapping.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (tick_i) begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (held_q) state_q <= DELAY;
        end
        DELAY: begin
          if (!held_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (REPEAT_EN && das_done) begin
            state_q <= REPEAT;
            cnt_q   <= '0;
          end else if (!das_done) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!held_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (arr_done) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_held_o = held_q;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Four debounced, auto-repeating KEY channels feeding the game FSM, with
// left/right mutual cancel and registered one-cycle action pulses.
module key_repeat_ctrl
  import tetris_input_pkg::*;
#(
  parameter int                    DEB_TICKS   = 2,
  parameter int                    DAS_TICKS   = 20,
  parameter int                    ARR_TICKS   = 5,
  parameter logic [NUM_KEYS-1:0]   REPEAT_MASK = 4'b1110
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                tick_input,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] act_pulse,
  output logic [NUM_KEYS-1:0] key_held
);

  logic [NUM_KEYS-1:0] fire;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] pulse_d;
  logic [NUM_KEYS-1:0] pulse_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .DEB_TICKS (DEB_TICKS),
      .DAS_TICKS (DAS_TICKS),
      .ARR_TICKS (ARR_TICKS),
      .REPEAT_EN (REPEAT_MASK[i])
    ) u_ch (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .tick_i     (tick_input),
      .key_n_i    (key_n[i]),
      .key_held_o (held[i]),
      .fire_o     (fire[i])
    );
  end

  // Both directions held: suppress the moves but let both FSMs keep counting.
  always_comb begin
    pulse_d = fire;
    if (held[KEY_LEFT] && held[KEY_RIGHT]) begin
      pulse_d[KEY_LEFT]  = 1'b0;
      pulse_d[KEY_RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign act_pulse = pulse_q;
  assign key_held  = held;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Self-checking bench for key_repeat_ctrl: directed scenarios plus random key
// activity, compared tick by tick against a hold-age reference model.
module tb_key_repeat_ctrl;

  localparam int DEB = 2;
  localparam int DAS = 20;
  localparam int ARR = 5;
  localparam logic [3:0] MASK = 4'b1110;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       tick_input;
  logic [3:0] key_n;
  logic [3:0] act_pulse;
  logic [3:0] key_held;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: debounced level, run of disagreeing samples,
  // and how many consecutive ticks the debounced level has been high.
  logic [3:0] held_m;
  int         run_m [4];
  int         age_m [4];

  key_repeat_ctrl dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .tick_input (tick_input),
    .key_n      (key_n),
    .act_pulse  (act_pulse),
    .key_held   (key_held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    held_m = '0;
    for (int i = 0; i < 4; i++) begin
      run_m[i] = 0;
      age_m[i] = 0;
    end
  endtask

  // Pulse schedule from hold age: age 1 fires; with repeat, age DAS+1 and
  // every ARR after that fire too.
  task automatic model_tick(output logic [3:0] exp_p);
    logic [3:0] raw;
    raw = ~key_n;
    for (int i = 0; i < 4; i++) begin
      age_m[i] = held_m[i] ? age_m[i] + 1 : 0;
      exp_p[i] = held_m[i] && ((age_m[i] == 1) ||
                 (MASK[i] && age_m[i] > DAS && ((age_m[i] - 1 - DAS) % ARR) == 0));
    end
    if (held_m[1] && held_m[2]) exp_p[2:1] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != held_m[i]) begin
        run_m[i]++;
        if (run_m[i] == DEB) begin
          held_m[i] = raw[i];
          run_m[i]  = 0;
        end
      end else begin
        run_m[i] = 0;
      end
    end
  endtask

  // Three quiet cycles let key_n settle through the synchronizer, then one
  // tick; outputs are sampled 1 ns after each edge.
  task automatic tick_step(output logic [3:0] seen);
    logic [3:0] exp_p;
    repeat (3) @(posedge CLOCK_50);
    #1;
    model_tick(exp_p);
    tick_input = 1'b1;
    @(posedge CLOCK_50);
    #1;
    tick_input = 1'b0;
    seen = act_pulse;
    check("act_pulse", act_pulse, exp_p);
    check("key_held", key_held, held_m);
    @(posedge CLOCK_50);
    #1;
    check("pulse_width", act_pulse, 4'b0000);
  endtask

  task automatic run_ticks(input int n, input logic [3:0] mask, output int cnt, output int first);
    logic [3:0] s;
    cnt   = 0;
    first = 0;
    for (int t = 1; t <= n; t++) begin
      tick_step(s);
      if ((s & mask) != 4'b0000) begin
        cnt++;
        if (first == 0) first = t;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    model_reset();
    check("reset_pulse", act_pulse, 4'b0000);
    check("reset_held", key_held, 4'b0000);
  endtask

  task automatic release_all();
    int c, f;
    key_n = 4'b1111;
    run_ticks(4, 4'b0000, c, f);
  endtask

  initial begin
    int         c, f;
    logic [3:0] s;

    resetn     = 1'b0;
    tick_input = 1'b0;
    key_n      = 4'b1111;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("init_pulse", act_pulse, 4'b0000);
    check("init_held", key_held, 4'b0000);
    resetn = 1'b1;

    // Right held: debounced after tick 2, pulses at 3, 23, 28, 33.
    key_n[1] = 1'b0;
    tick_step(s);
    check("s1_held_t1", key_held[1], 1'b0);
    tick_step(s);
    check("s1_held_t2", key_held[1], 1'b1);
    run_ticks(33, 4'b0010, c, f);
    check("s1_count", c, 4);
    check("s1_first", f + 2, 3);
    release_all();

    // Rotate held 100 ticks: a single pulse at tick 3.
    key_n[0] = 1'b0;
    run_ticks(100, 4'b0001, c, f);
    check("s2_count", c, 1);
    check("s2_first", f, 3);
    release_all();

    // One-tick glitch on left is rejected.
    key_n[2] = 1'b0;
    tick_step(s);
    key_n[2] = 1'b1;
    run_ticks(5, 4'b0100, c, f);
    check("s3_glitch", c, 0);

    // Bounce train then steady hold: exactly one first pulse.
    key_n[2] = 1'b0; tick_step(s);
    key_n[2] = 1'b1; tick_step(s);
    key_n[2] = 1'b0; tick_step(s);
    key_n[2] = 1'b1; tick_step(s);
    key_n[2] = 1'b0;
    run_ticks(12, 4'b0100, c, f);
    check("s3_bounce", c, 1);
    release_all();

    // Right held, left joins at tick 10, left leaves after tick 40.
    key_n[1] = 1'b0;
    run_ticks(9, 4'b0110, c, f);
    check("s4_pre", c, 1);
    key_n[2] = 1'b0;
    run_ticks(31, 4'b0110, c, f);
    check("s4_cancel", c, 0);
    key_n[2] = 1'b1;
    run_ticks(5, 4'b0010, c, f);
    check("s4_resume_first", f, 3);
    check("s4_resume_count", c, 1);
    release_all();

    // Drop released during DELAY: no pulse at 23; re-press fires 3 ticks later.
    key_n[3] = 1'b0;
    run_ticks(14, 4'b1000, c, f);
    key_n[3] = 1'b1;
    run_ticks(16, 4'b1000, c, f);
    check("s5_no_das", c, 0);
    key_n[3] = 1'b0;
    run_ticks(5, 4'b1000, c, f);
    check("s5_repress", f, 3);
    release_all();

    // Reset during REPEAT with the key still held.
    key_n[1] = 1'b0;
    run_ticks(30, 4'b0010, c, f);
    do_reset();
    run_ticks(5, 4'b0010, c, f);
    check("s6_after_reset", f, 3);

    // No ticks: everything frozen even while keys move.
    key_n = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLOCK_50);
      #1;
      check("frozen_pulse", act_pulse, 4'b0000);
      check("frozen_held", key_held, held_m);
    end
    release_all();

    // Random key activity with occasional resets.
    for (int n = 0; n < 400; n++) begin
      int r, k;
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 3);
      if (r < 18) key_n[k] = ~key_n[k];
      else if (r == 99) do_reset();
      tick_step(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
